// File: rtl/gmii_stats_pkg.sv
// Shared types and constants for the GMII per-frame statistics stage.
package gmii_stats_pkg;

    localparam int unsigned LEN_W = 16;
    localparam logic [7:0]  SFD   = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_WAIT_CRC
    } state_e;

    typedef enum logic [2:0] {
        CAT_NONE,
        CAT_GOOD,
        CAT_CRC_ERR,
        CAT_GMII_ERR,
        CAT_RUNT,
        CAT_OVERSIZE
    } cat_e;

    // First matching category wins: line error, runt, oversize, bad CRC, good.
    function automatic cat_e classify(
        input logic             er_seen,
        input logic [LEN_W-1:0] len,
        input logic             crc_ok,
        input logic [LEN_W-1:0] min_len,
        input logic [LEN_W-1:0] max_len
    );
        if (er_seen)            return CAT_GMII_ERR;
        else if (len < min_len) return CAT_RUNT;
        else if (len > max_len) return CAT_OVERSIZE;
        else if (!crc_ok)       return CAT_CRC_ERR;
        else                    return CAT_GOOD;
    endfunction

endpackage

// File: rtl/stats_counter.sv
// Saturating add-by-value counter with snapshot: latches the post-add value and clears.
module stats_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] add_i,
    input  logic             snap_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] live_q, live_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   sum_c;

    // The carry bit detects overflow; clamp to all-ones instead of wrapping.
    always_comb begin
        sum_c  = {1'b0, live_q} + {1'b0, add_i};
        live_d = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q  <= '0;
            count_q <= '0;
        end else begin
            live_q <= snap_i ? '0 : live_d;
            if (snap_i) count_q <= live_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gmii_frame_stats.sv
// Tracks GMII receive frames, classifies each one after the CRC verdict and
// keeps saturating per-category counters exposed through snapshot-and-clear.
module gmii_frame_stats
    import gmii_stats_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned OCT_WIDTH = 48,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           d,
    input  logic                 en,
    input  logic                 er,
    input  logic                 crc_ok,
    input  logic                 snapshot,
    output logic                 snapshot_valid,
    output logic [CNT_WIDTH-1:0] frames_total,
    output logic [CNT_WIDTH-1:0] frames_good,
    output logic [CNT_WIDTH-1:0] frames_crc_err,
    output logic [CNT_WIDTH-1:0] frames_gmii_err,
    output logic [CNT_WIDTH-1:0] frames_runt,
    output logic [CNT_WIDTH-1:0] frames_oversize,
    output logic [OCT_WIDTH-1:0] octets_good
);

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic             er_seen_q;
    logic             snap_valid_q;
    cat_e             cat_c;

    // Frame tracker; length saturates, er_seen restarts with every new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            er_seen_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q   <= ST_PREAMBLE;
                        er_seen_q <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (er) er_seen_q <= 1'b1;
                        if (d == SFD) begin
                            state_q <= ST_DATA;
                            len_q   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (en) begin
                        if (len_q != '1) len_q <= len_q + LEN_W'(1);
                        if (er) er_seen_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT_CRC;
                    end
                end
                ST_WAIT_CRC: begin
                    er_seen_q <= 1'b0;
                    state_q   <= en ? ST_PREAMBLE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cat_c = CAT_NONE;
        if (state_q == ST_WAIT_CRC)
            cat_c = classify(er_seen_q, len_q, crc_ok,
                             LEN_W'(MIN_LEN), LEN_W'(MAX_LEN));
    end

    logic [CNT_WIDTH-1:0] inc_total_c, inc_good_c, inc_crc_c;
    logic [CNT_WIDTH-1:0] inc_gmii_c, inc_runt_c, inc_over_c;
    logic [OCT_WIDTH-1:0] add_oct_c;

    assign inc_total_c = CNT_WIDTH'(cat_c != CAT_NONE);
    assign inc_good_c  = CNT_WIDTH'(cat_c == CAT_GOOD);
    assign inc_crc_c   = CNT_WIDTH'(cat_c == CAT_CRC_ERR);
    assign inc_gmii_c  = CNT_WIDTH'(cat_c == CAT_GMII_ERR);
    assign inc_runt_c  = CNT_WIDTH'(cat_c == CAT_RUNT);
    assign inc_over_c  = CNT_WIDTH'(cat_c == CAT_OVERSIZE);
    assign add_oct_c   = (cat_c == CAT_GOOD) ? OCT_WIDTH'(len_q) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) snap_valid_q <= 1'b0;
        else       snap_valid_q <= snapshot;
    end

    assign snapshot_valid = snap_valid_q;

    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_total (
        .clk(clk), .reset(reset), .add_i(inc_total_c), .snap_i(snapshot), .count_o(frames_total));
    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_good (
        .clk(clk), .reset(reset), .add_i(inc_good_c), .snap_i(snapshot), .count_o(frames_good));
    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_crc (
        .clk(clk), .reset(reset), .add_i(inc_crc_c), .snap_i(snapshot), .count_o(frames_crc_err));
    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_gmii (
        .clk(clk), .reset(reset), .add_i(inc_gmii_c), .snap_i(snapshot), .count_o(frames_gmii_err));
    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_runt (
        .clk(clk), .reset(reset), .add_i(inc_runt_c), .snap_i(snapshot), .count_o(frames_runt));
    stats_counter #(.WIDTH(CNT_WIDTH)) u_cnt_over (
        .clk(clk), .reset(reset), .add_i(inc_over_c), .snap_i(snapshot), .count_o(frames_oversize));
    stats_counter #(.WIDTH(OCT_WIDTH)) u_cnt_oct (
        .clk(clk), .reset(reset), .add_i(add_oct_c), .snap_i(snapshot), .count_o(octets_good));

endmodule

// File: tb/tb_gmii_frame_stats.sv
// Scoreboard bench for gmii_frame_stats with 4-bit frame counters so saturation is reachable.
module tb_gmii_frame_stats;

    localparam int unsigned CW = 4;
    localparam int unsigned OW = 48;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    d = 8'h00;
    logic          en = 1'b0;
    logic          er = 1'b0;
    logic          crc_ok = 1'b0;
    logic          snapshot = 1'b0;
    logic          snapshot_valid;
    logic [CW-1:0] frames_total, frames_good, frames_crc_err;
    logic [CW-1:0] frames_gmii_err, frames_runt, frames_oversize;
    logic [OW-1:0] octets_good;

    typedef struct packed {
        logic [CW-1:0] total;
        logic [CW-1:0] good;
        logic [CW-1:0] crc;
        logic [CW-1:0] gmii;
        logic [CW-1:0] runt;
        logic [CW-1:0] over;
        logic [OW-1:0] oct;
    } snap_t;

    snap_t exp_q[$];
    snap_t model = '0;
    snap_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    gmii_frame_stats #(.CNT_WIDTH(CW), .OCT_WIDTH(OW), .MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk(clk), .reset(reset), .d(d), .en(en), .er(er), .crc_ok(crc_ok),
        .snapshot(snapshot), .snapshot_valid(snapshot_valid),
        .frames_total(frames_total), .frames_good(frames_good),
        .frames_crc_err(frames_crc_err), .frames_gmii_err(frames_gmii_err),
        .frames_runt(frames_runt), .frames_oversize(frames_oversize),
        .octets_good(octets_good)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    task automatic cyc(input logic e, input logic [7:0] dd, input logic ee);
        en = e; d = dd; er = ee;
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input int len, input logic crc, input logic had_er);
        model.total = inc_sat(model.total);
        if (had_er)          model.gmii = inc_sat(model.gmii);
        else if (len < 64)   model.runt = inc_sat(model.runt);
        else if (len > 1518) model.over = inc_sat(model.over);
        else if (!crc)       model.crc  = inc_sat(model.crc);
        else begin
            model.good = inc_sat(model.good);
            model.oct  = model.oct + OW'(len);
        end
    endtask

    task automatic push_snap();
        exp_q.push_back(model);
        model = '0;
    endtask

    // Full frame; the last cycle is the WAIT_CRC cycle carrying crc_ok.
    task automatic send_frame(input int len, input logic crc, input int er_idx,
                              input logic snap_w, input logic b2b);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < len; i++) cyc(1'b1, 8'(i), i == er_idx);
        cyc(1'b0, 8'h00, 1'b0);
        crc_ok   = crc;
        snapshot = snap_w;
        model_add(len, crc, er_idx >= 0);
        if (snap_w) push_snap();
        cyc(b2b, 8'h55, 1'b0);
        crc_ok   = 1'b0;
        snapshot = 1'b0;
    endtask

    task automatic do_snap(input int n);
        for (int i = 0; i < n; i++) begin
            snapshot = 1'b1;
            push_snap();
            cyc(1'b0, 8'h00, 1'b0);
        end
        snapshot = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (snapshot_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_snapshot_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("frames_total",    64'(frames_total),    64'(mon_e.total));
                check("frames_good",     64'(frames_good),     64'(mon_e.good));
                check("frames_crc_err",  64'(frames_crc_err),  64'(mon_e.crc));
                check("frames_gmii_err", 64'(frames_gmii_err), 64'(mon_e.gmii));
                check("frames_runt",     64'(frames_runt),     64'(mon_e.runt));
                check("frames_oversize", 64'(frames_oversize), 64'(mon_e.over));
                check("octets_good",     64'(octets_good),     64'(mon_e.oct));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_total"}, 64'(frames_total), 64'd0);
        check({tag, "_good"},  64'(frames_good),  64'd0);
        check({tag, "_crc"},   64'(frames_crc_err), 64'd0);
        check({tag, "_gmii"},  64'(frames_gmii_err), 64'd0);
        check({tag, "_runt"},  64'(frames_runt),  64'd0);
        check({tag, "_over"},  64'(frames_oversize), 64'd0);
        check({tag, "_oct"},   64'(octets_good),  64'd0);
        check({tag, "_valid"}, 64'(snapshot_valid), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        cyc(1'b0, 8'h00, 1'b0);

        send_frame(64, 1'b1, -1, 1'b0, 1'b0);      // good
        do_snap(1);
        send_frame(64, 1'b0, -1, 1'b0, 1'b0);      // crc error
        do_snap(1);
        send_frame(60, 1'b1, -1, 1'b0, 1'b0);      // runt
        do_snap(1);
        send_frame(1519, 1'b1, -1, 1'b0, 1'b0);    // oversize
        do_snap(1);
        send_frame(64, 1'b1, 9, 1'b0, 1'b0);       // er on byte 10
        do_snap(1);

        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        do_snap(1);

        send_frame(100, 1'b1, -1, 1'b0, 1'b1);     // back-to-back, 1-cycle gap
        send_frame(200, 1'b1, -1, 1'b0, 1'b0);
        do_snap(1);

        send_frame(64, 1'b1, -1, 1'b1, 1'b0);      // snapshot on the WAIT_CRC edge
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        do_snap(1);

        send_frame(80, 1'b1, -1, 1'b0, 1'b0);      // held snapshot: second capture is zero
        do_snap(2);

        for (int k = 0; k < 17; k++) send_frame(1, 1'b0, -1, 1'b0, 1'b0);
        do_snap(1);

        // Live good frame plus a partial frame, both discarded by reset.
        send_frame(64, 1'b1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0);
        reset = 1'b1;
        model = '0;
        cyc(1'b1, 8'h20, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("midframe_reset");
        cyc(1'b0, 8'h00, 1'b0);
        send_frame(64, 1'b1, -1, 1'b0, 1'b0);
        do_snap(1);

        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
        check("pending_snapshots", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
